// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - round-robin arbiter with lock/timeout and registered access pipe for the shared frame BRAM
module bram_arbiter #(
  parameter int AW           = 10,
  parameter int DW           = 8,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [2:0]    i_req,
  input  logic [2:0]    i_we,
  input  logic [2:0]    i_lock,
  input  logic [AW-1:0] i_addr0,
  input  logic [AW-1:0] i_addr1,
  input  logic [AW-1:0] i_addr2,
  input  logic [DW-1:0] i_wdata0,
  input  logic [DW-1:0] i_wdata1,
  input  logic [DW-1:0] i_wdata2,
  output logic [2:0]    o_gnt,
  output logic [2:0]    o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic          o_timeout,
  output logic          o_mem_en,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {ST_IDLE, ST_OWNED} state_t;

  state_t        state_q, state_d;
  logic [1:0]    owner_q, owner_d;
  logic [1:0]    rr_last_q, rr_last_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;
  logic          p1_rd_q, p2_rd_q;
  logic [1:0]    p1_port_q, p2_port_q;

  logic [2:0]    gnt;
  logic [1:0]    gnt_idx;
  logic          timeout;
  logic          accept;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [1:0]    p1, p2, p3;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Search order for the idle round-robin, starting after the last granted port
  assign p1 = inc3(rr_last_q);
  assign p2 = inc3(p1);
  assign p3 = inc3(p2);

  always_comb begin
    gnt       = 3'b000;
    gnt_idx   = 2'd0;
    timeout   = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_req[p1])      begin gnt_idx = p1; gnt = 3'b001 << p1; end
        else if (i_req[p2]) begin gnt_idx = p2; gnt = 3'b001 << p2; end
        else if (i_req[p3]) begin gnt_idx = p3; gnt = 3'b001 << p3; end
        if (gnt != 3'b000) begin
          rr_last_d = gnt_idx;
          if (i_lock[gnt_idx]) begin
            state_d = ST_OWNED;
            owner_d = gnt_idx;
            cnt_d   = '0;
          end
        end
      end
      ST_OWNED: begin
        gnt_idx = owner_q;
        // The timeout cycle grants nobody; waiting ports win from the next cycle
        if (cnt_q == CW'(LOCK_TIMEOUT)) begin
          timeout = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (i_req[owner_q]) begin
          gnt       = 3'b001 << owner_q;
          rr_last_d = owner_q;
          cnt_d     = '0;
          if (!i_lock[owner_q]) state_d = ST_IDLE;
        end else if (!i_lock[owner_q]) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = |gnt;

  always_comb begin
    sel_we    = i_we[0];
    sel_addr  = i_addr0;
    sel_wdata = i_wdata0;
    case (gnt_idx)
      2'd1: begin sel_we = i_we[1]; sel_addr = i_addr1; sel_wdata = i_wdata1; end
      2'd2: begin sel_we = i_we[2]; sel_addr = i_addr2; sel_wdata = i_wdata2; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      owner_q   <= 2'd0;
      rr_last_q <= 2'd2;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
    end
  end

  // Two-stage {read, port} pipe lines o_rvalid up with the BRAM read latency
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      p1_rd_q     <= 1'b0;
      p1_port_q   <= 2'd0;
      p2_rd_q     <= 1'b0;
      p2_port_q   <= 2'd0;
    end else begin
      mem_en_q  <= accept;
      mem_we_q  <= accept & sel_we;
      if (accept) begin
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_wdata;
      end
      p1_rd_q   <= accept & ~sel_we;
      p1_port_q <= gnt_idx;
      p2_rd_q   <= p1_rd_q;
      p2_port_q <= p1_port_q;
    end
  end

  assign o_gnt       = gnt;
  assign o_timeout   = timeout;
  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_rvalid    = p2_rd_q ? (3'b001 << p2_port_q) : 3'b000;
  assign o_rdata     = i_mem_rdata;

endmodule
